free_list: RTL and testbench
============================

# free_list

Circular FIFO of free physical register indices that feeds the rename/dispatch stage. Each dispatch pops SS entries; each commit returns up to SS retired (stale) physical registers. At reset it holds every physical register not mapped to an architectural register: indices 32..PR_ENTRIES-1. It sits beside the RAT, between commit/retire and rename/dispatch.

## Interface
- SS, 2: superscalar width, the number of entries popped or pushed per cycle.
- PR_ENTRIES, 64: number of physical registers. DEPTH = PR_ENTRIES-32 must be a power of two and at least SS.
- clk  in  1: clock.
- rst  in  1: reset, synchronous and active-high.
- pop_free_list  in  1: consume the SS head entries this cycle. Driven by the same condition as the instruction-queue pop.
- free_list_regs  out  [SS] x $clog2(PR_ENTRIES): head entries. Lane i = mem[head+i], combinational from registered state.
- free_avail  out  1: high when count ≥ SS.
- push_valid  in  [SS] x 1: per-lane valid for a returned register.
- push_reg  in  [SS] x $clog2(PR_ENTRIES): physical register freed at commit.
- free_count  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- State:
  - mem[DEPTH] of physical register indices.
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH naturally.
  - count register.
- Reset:
  - mem[i] = 32+i.
  - head = 0, tail = 0.
  - count = DEPTH, so free_avail = 1.
  - free_list_regs = {32, 33, …}.
- Pop:
  - Effective pop = pop_free_list & free_avail.
  - On effective pop, head advances by SS and count decreases by SS.
  - pop_free_list while !free_avail is a protocol error. It is ignored (no state change) and flagged by a simulation assertion.
- Push:
  - Valid lanes are compacted in lane order. The k-th valid lane is written to mem[tail+k].
  - tail advances by popcount(push_valid), and count increases by the same amount.
  - Invalid lanes write nothing, including interior gaps. For example, push_valid = {1,0} writes lane 0 only.
- Register 0 is never freed. A push lane carrying push_reg = 0 is treated as invalid.
- Simultaneous pop and push:
  - Both occur in the same cycle.
  - count_next = count - SS·pop + popcount(push).
  - Pushed entries become visible on free_list_regs at the earliest in the next cycle. There is no same-cycle bypass from push to head.
- Overflow:
  - count + pushes > DEPTH cannot happen when renaming is correct.
  - If it occurs, the excess lanes are dropped and an assertion fires.
  - count saturates at DEPTH.
- Wrap-around: pointer arithmetic is modulo DEPTH. Read indices head+i and write indices tail+k wrap independently.

## Timing
- free_list_regs and free_avail are valid in the same cycle as the state they reflect. The consumer samples them in the cycle it asserts pop_free_list.
- After a pop at edge N, the new head entries appear after edge N. The latency is one cycle.
- A push at edge N is readable from edge N onward, once head reaches it.
- Reset mid-operation restores the full reset state at the next edge. All in-flight pushes in that cycle are discarded.
- There are no multi-cycle operations and no stalls internal to the block.

## Structure
- Add to the shared rv32i_types package:
  - constant ARCH_REGS = 32.
  - typedef of the physical register index, $clog2(PR_ENTRIES) bits.
- Compute DEPTH locally from the parameters, with an elaboration-time check that it is a power of two.
- Natural sub-module: circular_queue, a generic multi-push/multi-pop ring with pointers and count. free_list wraps it, adding reset-time contents, lane compaction and register-0 filtering.
- Lane compaction is a small prefix-sum over push_valid, written as a combinational loop.

## Test plan
- Reset, then sample with no pop: free_list_regs = {32, 33}, free_count = 32, free_avail = 1.
- Pop for 16 consecutive cycles (SS = 2): the entries observed are 32..63 in order. Afterwards free_count = 0, free_avail = 0, and a further pop leaves state unchanged.
- From empty, push {40, 41}, then push {50 valid, lane 1 invalid}: free_count = 3, free_list_regs = {40, 41}. After one pop, lane 0 = 50.
- Steady state at count = 4: simultaneous pop plus two pushes gives count = 4 next cycle. The pushed registers appear after the remaining two heads.
- Pointer wrap: drain and refill repeatedly for more than 40 cycles with a random push pattern. Checked against a scoreboard queue model, the output sequence matches exactly and no register appears twice.
- Push lane carrying register 0, plus rst asserted mid-stream: register 0 never appears on the outputs. The cycle after rst shows {32, 33} with count = 32.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared rename-stage definitions used by the free list and its neighbours.
package free_list_pkg;

    // Architectural registers are mapped at reset, so they never start out free.
    localparam int ARCH_REGS = 32;

    // Default physical register file size and the matching index type.
    localparam int PR_ENTRIES_DEFAULT = 64;
    typedef logic [$clog2(PR_ENTRIES_DEFAULT)-1:0] phys_reg_t;

endpackage

// File: rtl/free_list_if.sv
// Rename-side and commit-side signals of the free list.
//
// Handshake: the consumer samples free_list_regs/free_avail and raises
// pop_free_list in the same cycle; a pop only takes effect when free_avail is
// high. Each push lane is consumed on every edge where push_valid[i] is high
// and push_reg[i] is non-zero; there is no ready, because returns are
// guaranteed to fit when renaming is correct.
interface free_list_if
    import free_list_pkg::*;
#(
    parameter int SS         = 2,
    parameter int PR_ENTRIES = 64
);
    localparam int PR_W  = $clog2(PR_ENTRIES);
    localparam int CNT_W = $clog2(PR_ENTRIES - ARCH_REGS) + 1;

    logic              pop_free_list;
    logic [PR_W-1:0]   free_list_regs [SS];
    logic              free_avail;
    logic [SS-1:0]     push_valid;
    logic [PR_W-1:0]   push_reg [SS];
    logic [CNT_W-1:0]  free_count;

    // Rename/commit side: drives pops and returns, observes the head.
    modport master (
        output pop_free_list, push_valid, push_reg,
        input  free_list_regs, free_avail, free_count
    );

    // The free list itself.
    modport slave (
        input  pop_free_list, push_valid, push_reg,
        output free_list_regs, free_avail, free_count
    );
endinterface

// File: rtl/circular_queue.sv
// Generic ring: SS entries popped at once, up to SS compacted entries pushed.
// Contents are loaded from init_data on reset; the ring starts full.
module circular_queue #(
    parameter int DEPTH = 32,
    parameter int W     = 6,
    parameter int SS    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             init_data [DEPTH],
    input  logic                     pop,
    input  logic [$clog2(SS+1)-1:0]  wr_cnt,
    input  logic [W-1:0]             wr_data [SS],
    output logic [W-1:0]             rd_data [SS],
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LC_W  = $clog2(SS + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] rd_idx [SS];
    logic [PTR_W-1:0] wr_idx [SS];

    // Read and write slot indices wrap modulo DEPTH independently.
    always_comb begin
        for (int i = 0; i < SS; i++) begin
            rd_idx[i]  = head + PTR_W'(i);
            wr_idx[i]  = tail + PTR_W'(i);
            rd_data[i] = mem[rd_idx[i]];
        end
    end

    // Pointer, count and storage update; reset reloads the initial contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= init_data[i];
            end
        end else begin
            if (pop) begin
                head <= head + PTR_W'(SS);
            end
            tail  <= tail + PTR_W'(wr_cnt);
            count <= count - (pop ? CNT_W'(SS) : '0) + CNT_W'(wr_cnt);
            for (int k = 0; k < SS; k++) begin
                if (LC_W'(k) < wr_cnt) begin
                    mem[wr_idx[k]] <= wr_data[k];
                end
            end
        end
    end
endmodule

// File: rtl/free_list.sv
// Free physical register list between commit and rename. Starts holding
// every non-architectural register; pops SS heads per dispatch and takes back
// up to SS stale registers per commit.
module free_list
    import free_list_pkg::*;
#(
    parameter int SS         = 2,
    parameter int PR_ENTRIES = 64
) (
    input  logic      clk,
    input  logic      rst,
    free_list_if.slave fl
);
    localparam int DEPTH = PR_ENTRIES - ARCH_REGS;
    localparam int PR_W  = $clog2(PR_ENTRIES);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SP_W  = CNT_W + 1;
    localparam int LC_W  = $clog2(SS + 1);

    if (DEPTH < SS || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("free_list: PR_ENTRIES-32 must be a power of two and >= SS");
    end

    logic [PR_W-1:0]  init_data [DEPTH];
    logic [PR_W-1:0]  wr_data [SS];
    logic [PR_W-1:0]  rd_data [SS];
    logic [CNT_W-1:0] count;
    logic             free_avail;
    logic             pop_eff;
    logic             lane_ok [SS];
    logic [LC_W-1:0]  lane_off [SS];
    logic [LC_W-1:0]  n_valid;
    logic [LC_W-1:0]  wr_cnt;
    logic [SP_W-1:0]  space;
    logic             overflow;

    // Reset contents: slot i holds register ARCH_REGS+i.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            init_data[i] = PR_W'(ARCH_REGS + i);
        end
    end

    // Head status; pops while fewer than SS entries remain are ignored.
    always_comb begin
        free_avail        = (count >= CNT_W'(SS));
        pop_eff           = fl.pop_free_list && free_avail;
        fl.free_avail     = free_avail;
        fl.free_count     = count;
        fl.free_list_regs = rd_data;
    end

    // Prefix sum over usable lanes; register 0 is never a legal return.
    always_comb begin
        n_valid = '0;
        for (int i = 0; i < SS; i++) begin
            lane_ok[i]  = fl.push_valid[i] && (fl.push_reg[i] != '0);
            lane_off[i] = n_valid;
            n_valid     = n_valid + LC_W'(lane_ok[i]);
        end
    end

    // Clamp returns to the free slots, counting the slots a pop frees now.
    always_comb begin
        space    = SP_W'(DEPTH) - SP_W'(count) + (pop_eff ? SP_W'(SS) : '0);
        overflow = SP_W'(n_valid) > space;
        wr_cnt   = overflow ? LC_W'(space) : n_valid;
    end

    // Compaction: the k-th usable lane goes to write slot k.
    always_comb begin
        for (int k = 0; k < SS; k++) begin
            wr_data[k] = '0;
            for (int i = 0; i < SS; i++) begin
                if (lane_ok[i] && lane_off[i] == LC_W'(k)) begin
                    wr_data[k] = fl.push_reg[i];
                end
            end
        end
    end

    circular_queue #(
        .DEPTH (DEPTH),
        .W     (PR_W),
        .SS    (SS)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .init_data (init_data),
        .pop       (pop_eff),
        .wr_cnt    (wr_cnt),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .count     (count)
    );

    // Flag consumer protocol errors and impossible over-returns.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fl.pop_free_list && !free_avail))
                else $warning("free_list: pop without free_avail ignored");
            assert (!overflow)
                else $warning("free_list: returns exceed free slots, excess dropped");
        end
    end
endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: reset checks, a directed vector table, random
// drain/refill traffic against a queue model, and a mid-stream reset.
module tb_free_list;
    import free_list_pkg::*;

    localparam int SS         = 2;
    localparam int PR_ENTRIES = 64;
    localparam int DEPTH      = PR_ENTRIES - ARCH_REGS;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   model_q [$];

    free_list_if #(.SS(SS), .PR_ENTRIES(PR_ENTRIES)) fl ();

    free_list #(.SS(SS), .PR_ENTRIES(PR_ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl.slave)
    );

    typedef struct {
        logic       pop;
        logic [1:0] pv;
        int         r0;
        int         r1;
        int         e_cnt;
        int         e_avail;
        int         e_l0;
        int         e_l1;
    } vec_t;

    vec_t tbl [12];

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        model_q.delete();
        for (int i = 0; i < DEPTH; i++) model_q.push_back(ARCH_REGS + i);
    endfunction

    function automatic bit in_model(input int r);
        foreach (model_q[i]) if (model_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Spec-level behaviour: pop SS if at least SS held, then append usable
    // returns in lane order while there is room.
    function automatic void model_step(input logic pop, input logic [1:0] pv, input int r0, input int r1);
        int r [2];
        r[0] = r0;
        r[1] = r1;
        if (pop && model_q.size() >= SS) begin
            for (int i = 0; i < SS; i++) void'(model_q.pop_front());
        end
        for (int l = 0; l < SS; l++) begin
            if (pv[l] && r[l] != 0 && model_q.size() < DEPTH) model_q.push_back(r[l]);
        end
    endfunction

    function automatic int pick_reg(input int avoid);
        int r;
        for (int t = 0; t < 500; t++) begin
            r = int'($urandom_range(PR_ENTRIES - 1, 1));
            if (r != avoid && !in_model(r)) return r;
        end
        return 0;
    endfunction

    // Called at a negedge: compare outputs with the model.
    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"}, 32'(fl.free_count), 32'(n));
        chk({tag, ".avail"}, 32'(fl.free_avail), 32'(n >= SS));
        for (int i = 0; i < SS; i++) begin
            if (i < n) chk($sformatf("%s.lane%0d", tag, i), 32'(fl.free_list_regs[i]), 32'(model_q[i]));
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, return at next negedge.
    task automatic drive(input logic pop, input logic [1:0] pv, input int r0, input int r1);
        fl.pop_free_list = pop;
        fl.push_valid    = pv;
        fl.push_reg[0]   = phys_reg_t'(r0);
        fl.push_reg[1]   = phys_reg_t'(r1);
        @(posedge clk);
        model_step(pop, pv, r0, r1);
        @(negedge clk);
        fl.pop_free_list = 1'b0;
        fl.push_valid    = '0;
    endtask

    initial begin
        logic       pop;
        logic [1:0] pv;
        int         r0, r1;
        bit         drain;

        rst              = 1'b1;
        fl.pop_free_list = 1'b0;
        fl.push_valid    = '0;
        fl.push_reg[0]   = '0;
        fl.push_reg[1]   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset state with no pop.
        chk("reset.count", 32'(fl.free_count), 32);
        chk("reset.avail", 32'(fl.free_avail), 1);
        chk("reset.lane0", 32'(fl.free_list_regs[0]), 32);
        chk("reset.lane1", 32'(fl.free_list_regs[1]), 33);

        // Sixteen consecutive pops observe 32..63 in order.
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d.lane0", k), 32'(fl.free_list_regs[0]), 32'(32 + 2 * k));
            chk($sformatf("drain%0d.lane1", k), 32'(fl.free_list_regs[1]), 32'(33 + 2 * k));
            drive(1'b1, 2'b00, 0, 0);
        end
        chk("drained.count", 32'(fl.free_count), 0);
        chk("drained.avail", 32'(fl.free_avail), 0);

        // Directed vectors from empty: outputs checked before inputs apply.
        tbl[0]  = '{1'b1, 2'b00,  0,  0, 0, 0, -1, -1}; // pop at empty ignored
        tbl[1]  = '{1'b0, 2'b11, 40, 41, 0, 0, -1, -1};
        tbl[2]  = '{1'b0, 2'b01, 50, 55, 2, 1, 40, 41}; // lane 1 invalid
        tbl[3]  = '{1'b1, 2'b00,  0,  0, 3, 1, 40, 41};
        tbl[4]  = '{1'b0, 2'b11, 60, 61, 1, 0, 50, -1};
        tbl[5]  = '{1'b0, 2'b01, 62, 44, 3, 1, 50, 60};
        tbl[6]  = '{1'b1, 2'b11, 33, 34, 4, 1, 50, 60}; // pop + two pushes
        tbl[7]  = '{1'b1, 2'b00,  0,  0, 4, 1, 61, 62};
        tbl[8]  = '{1'b0, 2'b11,  0, 35, 2, 1, 33, 34}; // register 0 lane
        tbl[9]  = '{1'b1, 2'b00,  0,  0, 3, 1, 33, 34};
        tbl[10] = '{1'b0, 2'b10, 45, 46, 1, 0, 35, -1}; // lane 0 gap
        tbl[11] = '{1'b0, 2'b00,  0,  0, 2, 1, 35, 46};
        for (int v = 0; v < 12; v++) begin
            chk($sformatf("vec%0d.count", v), 32'(fl.free_count), 32'(tbl[v].e_cnt));
            chk($sformatf("vec%0d.avail", v), 32'(fl.free_avail), 32'(tbl[v].e_avail));
            if (tbl[v].e_l0 >= 0) chk($sformatf("vec%0d.lane0", v), 32'(fl.free_list_regs[0]), 32'(tbl[v].e_l0));
            if (tbl[v].e_l1 >= 0) chk($sformatf("vec%0d.lane1", v), 32'(fl.free_list_regs[1]), 32'(tbl[v].e_l1));
            drive(tbl[v].pop, tbl[v].pv, tbl[v].r0, tbl[v].r1);
        end

        // Random drain/refill phases against the queue model.
        for (int c = 0; c < 120; c++) begin
            check_model($sformatf("rnd%0d", c));
            drain = ((c / 12) % 2) == 0;
            pop   = drain ? ($urandom_range(9, 0) < 8) : ($urandom_range(9, 0) < 2);
            pv[0] = drain ? ($urandom_range(9, 0) < 2) : ($urandom_range(9, 0) < 8);
            pv[1] = drain ? ($urandom_range(9, 0) < 2) : ($urandom_range(9, 0) < 8);
            r0    = pick_reg(-1);
            r1    = pick_reg(r0);
            if ($urandom_range(7, 0) == 0) r0 = 0;
            drive(pop, pv, r0, r1);
        end
        check_model("rnd_end");

        // Reset asserted mid-stream with pushes and a pop in flight.
        fl.pop_free_list = 1'b1;
        fl.push_valid    = 2'b11;
        fl.push_reg[0]   = phys_reg_t'(5);
        fl.push_reg[1]   = phys_reg_t'(6);
        rst              = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst              = 1'b0;
        fl.pop_free_list = 1'b0;
        fl.push_valid    = '0;
        chk("midrst.count", 32'(fl.free_count), 32);
        chk("midrst.lane0", 32'(fl.free_list_regs[0]), 32);
        chk("midrst.lane1", 32'(fl.free_list_regs[1]), 33);
        drive(1'b1, 2'b00, 0, 0);
        check_model("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
